// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised serial-pattern detector.
// prefix_suffix_len builds the KMP transition table; it is only ever evaluated on constants.
package seq_det_pkg;

  localparam int PAT_LEN_MIN = 1;
  localparam int PAT_LEN_MAX = 16;

  function automatic int state_width(input int pat_len);
    return (pat_len < 1) ? 1 : $clog2(pat_len + 1);
  endfunction

  // history holds hist_len valid bits with the newest bit at bit 0; pattern is MSB-first
  // over its low len bits. Returns the longest l such that the last l history bits equal
  // the first l pattern bits.
  function automatic int prefix_suffix_len(input logic [PAT_LEN_MAX-1:0] pattern,
                                           input int len,
                                           input logic [PAT_LEN_MAX-1:0] history,
                                           input int hist_len);
    int best;
    bit ok;
    best = 0;
    for (int l = 1; l <= len && l <= hist_len; l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++) begin
        if (history[i] != pattern[len - l + i]) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_det_next.sv
// Combinational next-state logic of the KMP matcher: (state, w, overlap) -> next_state.
// The whole transition table is folded to constants at elaboration.
module seq_det_next
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter int                 ST_W    = state_width(PAT_LEN)
) (
  input  logic [ST_W-1:0] state,
  input  logic            w,
  input  logic            overlap,
  output logic [ST_W-1:0] next_state
);

  localparam logic [PAT_LEN_MAX-1:0] PAT_X = PAT_LEN_MAX'(PATTERN);

  // Row PAT_LEN is the overlapping exit from a full match; the non-overlap exit reuses row 0.
  logic [ST_W-1:0] tbl [PAT_LEN+1][2];

  for (genvar k = 0; k <= PAT_LEN; k++) begin : g_row
    for (genvar b = 0; b < 2; b++) begin : g_col
      localparam logic [PAT_LEN_MAX-1:0] HIST = (k < PAT_LEN)
          ? (((PAT_X >> (PAT_LEN - k)) << 1) | PAT_LEN_MAX'(b))
          : ((PAT_X << 1) | PAT_LEN_MAX'(b));
      localparam int NXT = prefix_suffix_len(PAT_X, PAT_LEN, HIST,
                                             (k < PAT_LEN) ? k + 1 : PAT_LEN);
      assign tbl[k][b] = ST_W'(NXT);
    end
  end

  // Encodings above PAT_LEN fall through to the default of 0.
  always_comb begin
    next_state = '0;
    for (int k = 0; k < PAT_LEN; k++) begin
      if (state == ST_W'(k)) next_state = tbl[k][w];
    end
    if (state == ST_W'(PAT_LEN)) begin
      next_state = overlap ? tbl[PAT_LEN][w] : tbl[0][w];
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Moore serial-pattern detector with clock enable, runtime overlap mode
// and a saturating match counter with sticky saturation flag.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter int                 CNT_W   = 8,
  localparam int                ST_W    = state_width(PAT_LEN)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             en,
  input  logic             w,
  input  logic             overlap,
  output logic [ST_W-1:0]  state,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  if ((PAT_LEN < PAT_LEN_MIN) || (PAT_LEN > PAT_LEN_MAX) || (CNT_W < 1)) begin : g_bad_params
    $error("seq_detector_param: PAT_LEN must be 1..16 and CNT_W >= 1");
  end

  localparam logic [ST_W-1:0]  FULL    = ST_W'(PAT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [ST_W-1:0] next_state;

  seq_det_next #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN),
    .ST_W    (ST_W)
  ) u_next (
    .state      (state),
    .w          (w),
    .overlap    (overlap),
    .next_state (next_state)
  );

  // Counter advances on every en edge that lands in FULL, including FULL -> FULL.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= '0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (clear) begin
      state       <= '0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (en) begin
      state <= next_state;
      if ((next_state == FULL) && (match_count != CNT_MAX)) begin
        match_count <= match_count + CNT_W'(1);
        if (match_count == (CNT_MAX - CNT_W'(1))) count_sat <= 1'b1;
      end
    end
  end

  assign match = (state == FULL);

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: five parameterisations share one input stream and are
// compared against a string-matching reference model plus directed scenarios.
module tb_seq_detector_param;

  localparam int NDUT = 5;

  logic clock, resetn, clear, en, w, overlap;

  logic [2:0] st_a, st_b, st_c, st_d;
  logic [0:0] st_e;
  logic       m_a, m_b, m_c, m_d, m_e;
  logic [7:0] c_a, c_b;
  logic [1:0] c_c;
  logic [3:0] c_d;
  logic [2:0] c_e;
  logic       s_a, s_b, s_c, s_d, s_e;

  seq_detector_param u_a (
    .clock(clock), .resetn(resetn), .clear(clear), .en(en), .w(w), .overlap(overlap),
    .state(st_a), .match(m_a), .match_count(c_a), .count_sat(s_a));
  seq_detector_param #(.PATTERN(4'b1111)) u_b (
    .clock(clock), .resetn(resetn), .clear(clear), .en(en), .w(w), .overlap(overlap),
    .state(st_b), .match(m_b), .match_count(c_b), .count_sat(s_b));
  seq_detector_param #(.CNT_W(2)) u_c (
    .clock(clock), .resetn(resetn), .clear(clear), .en(en), .w(w), .overlap(overlap),
    .state(st_c), .match(m_c), .match_count(c_c), .count_sat(s_c));
  seq_detector_param #(.PAT_LEN(5), .PATTERN(5'b10010), .CNT_W(4)) u_d (
    .clock(clock), .resetn(resetn), .clear(clear), .en(en), .w(w), .overlap(overlap),
    .state(st_d), .match(m_d), .match_count(c_d), .count_sat(s_d));
  seq_detector_param #(.PAT_LEN(1), .PATTERN(1'b0), .CNT_W(3)) u_e (
    .clock(clock), .resetn(resetn), .clear(clear), .en(en), .w(w), .overlap(overlap),
    .state(st_e), .match(m_e), .match_count(c_e), .count_sat(s_e));

  int p_len [NDUT] = '{4, 4, 4, 5, 1};
  int p_val [NDUT] = '{13, 15, 13, 18, 0};
  int c_max [NDUT] = '{255, 255, 3, 15, 7};

  // Reference model: recent consumed bits (newest at bit 0) since the last restart point.
  logic [31:0] m_hist  [NDUT];
  int          m_hcnt  [NDUT];
  int          m_state [NDUT];
  int          m_cnt   [NDUT];
  int          m_sat   [NDUT];

  logic [31:0] obs_state [NDUT];
  logic [31:0] obs_match [NDUT];
  logic [31:0] obs_cnt   [NDUT];
  logic [31:0] obs_sat   [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int model_longest(int d);
    logic [31:0] mask;
    for (int l = m_hcnt[d]; l >= 1; l--) begin
      mask = (32'd1 << l) - 32'd1;
      if ((m_hist[d] & mask) == (32'(p_val[d]) >> (p_len[d] - l))) return l;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_hist[d] = '0; m_hcnt[d] = 0; m_state[d] = 0; m_cnt[d] = 0; m_sat[d] = 0;
    end
  endtask

  task automatic model_edge();
    if (clear) begin
      model_reset();
    end else if (en) begin
      for (int d = 0; d < NDUT; d++) begin
        if (m_state[d] == p_len[d] && !overlap) begin
          m_hist[d] = '0; m_hcnt[d] = 0;
        end
        m_hist[d] = {m_hist[d][30:0], w};
        if (m_hcnt[d] < p_len[d]) m_hcnt[d]++;
        m_state[d] = model_longest(d);
        if (m_state[d] == p_len[d]) begin
          if (m_cnt[d] < c_max[d]) m_cnt[d]++;
          if (m_cnt[d] == c_max[d]) m_sat[d] = 1;
        end
      end
    end
  endtask

  task automatic sample_obs();
    obs_state[0] = 32'(st_a); obs_state[1] = 32'(st_b); obs_state[2] = 32'(st_c);
    obs_state[3] = 32'(st_d); obs_state[4] = 32'(st_e);
    obs_match[0] = 32'(m_a); obs_match[1] = 32'(m_b); obs_match[2] = 32'(m_c);
    obs_match[3] = 32'(m_d); obs_match[4] = 32'(m_e);
    obs_cnt[0] = 32'(c_a); obs_cnt[1] = 32'(c_b); obs_cnt[2] = 32'(c_c);
    obs_cnt[3] = 32'(c_d); obs_cnt[4] = 32'(c_e);
    obs_sat[0] = 32'(s_a); obs_sat[1] = 32'(s_b); obs_sat[2] = 32'(s_c);
    obs_sat[3] = 32'(s_d); obs_sat[4] = 32'(s_e);
  endtask

  task automatic drive(input bit en_i, input bit w_i, input bit ovl_i, input bit clr_i);
    @(negedge clock);
    en = en_i; w = w_i; overlap = ovl_i; clear = clr_i;
    @(posedge clock);
    model_edge();
    #1;
    sample_obs();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    #1 resetn = 1'b0;
    model_reset();
    #1 sample_obs();
    #1 resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; clear = 1'b0; en = 1'b1; w = 1'b1; overlap = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1 sample_obs();
    for (int d = 0; d < NDUT; d++) begin
      n_checks++;
      if (obs_state[d] !== 0 || obs_match[d] !== 0 || obs_cnt[d] !== 0 || obs_sat[d] !== 0) begin
        n_fail++;
        $display("FAIL reset dut%0d state=%0h match=%0h cnt=%0h sat=%0h required all 0",
                 d, obs_state[d], obs_match[d], obs_cnt[d], obs_sat[d]);
      end
    end
    @(negedge clock) resetn = 1'b1;
  endtask

  task automatic test_overlap_1101(input bit ovl);
    logic [6:0] bits;
    int exp_st [7];
    bits = 7'b1101101;
    if (ovl) exp_st = '{1, 2, 3, 4, 2, 3, 4};
    else     exp_st = '{1, 2, 3, 4, 1, 0, 1};
    drive(1'b1, 1'b0, ovl, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, bits[6 - i], ovl, 1'b0);
      n_checks++;
      if (obs_state[0] !== exp_st[i] || obs_match[0] !== 32'(exp_st[i] == 4)) begin
        n_fail++;
        $display("FAIL ovl%0d_1101 bit%0d state=%0h match=%0h required state=%0d match=%0d",
                 ovl, i + 1, obs_state[0], obs_match[0], exp_st[i], exp_st[i] == 4);
      end
    end
    n_checks++;
    if (obs_cnt[0] !== (ovl ? 2 : 1)) begin
      n_fail++;
      $display("FAIL ovl%0d_1101_count got=%0h required=%0d", ovl, obs_cnt[0], ovl ? 2 : 1);
    end
  endtask

  task automatic test_all_ones();
    int exp_o [5] = '{1, 2, 3, 4, 4};
    int exp_n [8] = '{1, 2, 3, 4, 1, 2, 3, 4};
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (obs_state[1] !== exp_o[i] || obs_match[1] !== 32'(exp_o[i] == 4)) begin
        n_fail++;
        $display("FAIL ones_ovl bit%0d state=%0h match=%0h required state=%0d",
                 i + 1, obs_state[1], obs_match[1], exp_o[i]);
      end
    end
    n_checks++;
    if (obs_cnt[1] !== 2) begin
      n_fail++;
      $display("FAIL ones_ovl_count got=%0h required=2", obs_cnt[1]);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs_state[1] !== exp_n[i] || obs_match[1] !== 32'(exp_n[i] == 4)) begin
        n_fail++;
        $display("FAIL ones_novl bit%0d state=%0h match=%0h required state=%0d",
                 i + 1, obs_state[1], obs_match[1], exp_n[i]);
      end
    end
    n_checks++;
    if (obs_cnt[1] !== 2) begin
      n_fail++;
      $display("FAIL ones_novl_count got=%0h required=2", obs_cnt[1]);
    end
  endtask

  task automatic test_enable_gaps();
    logic [3:0] bits;
    int exp_st [4] = '{1, 2, 3, 4};
    bits = 4'b1101;
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, bits[3 - i], 1'b1, 1'b0);
      for (int j = 0; j < 2; j++) begin
        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        n_checks++;
        if (obs_state[0] !== exp_st[i] || obs_match[0] !== 32'(exp_st[i] == 4)) begin
          n_fail++;
          $display("FAIL en_hold bit%0d state=%0h match=%0h required state=%0d",
                   i + 1, obs_state[0], obs_match[0], exp_st[i]);
        end
      end
    end
    n_checks++;
    if (obs_cnt[0] !== 1) begin
      n_fail++;
      $display("FAIL en_hold_count got=%0h required=1", obs_cnt[0]);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs_state[0] !== 0 || obs_match[0] !== 0) begin
      n_fail++;
      $display("FAIL en_match_drop state=%0h match=%0h required 0", obs_state[0], obs_match[0]);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] bits;
    int exp_c;
    bits = 4'b1101;
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 4; i++) drive(1'b1, bits[3 - i], 1'b0, 1'b0);
      exp_c = (k < 3) ? k : 3;
      n_checks++;
      if (obs_cnt[2] !== exp_c || obs_sat[2] !== 32'(k >= 3) || obs_match[2] !== 1) begin
        n_fail++;
        $display("FAIL sat match%0d cnt=%0h sat=%0h match=%0h required cnt=%0d sat=%0d",
                 k, obs_cnt[2], obs_sat[2], obs_match[2], exp_c, k >= 3);
      end
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (obs_cnt[2] !== 0 || obs_sat[2] !== 0 || obs_state[2] !== 0) begin
      n_fail++;
      $display("FAIL sat_clear cnt=%0h sat=%0h state=%0h required 0",
               obs_cnt[2], obs_sat[2], obs_state[2]);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs_state[0] !== 3) begin
      n_fail++;
      $display("FAIL pre_reset state=%0h required=3", obs_state[0]);
    end
    pulse_reset();
    n_checks++;
    if (obs_state[0] !== 0 || obs_cnt[0] !== 0 || obs_match[0] !== 0) begin
      n_fail++;
      $display("FAIL async_reset state=%0h cnt=%0h match=%0h required 0",
               obs_state[0], obs_cnt[0], obs_match[0]);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs_state[0] !== 1 || obs_match[0] !== 0) begin
      n_fail++;
      $display("FAIL post_reset_1 state=%0h match=%0h required state=1 match=0",
               obs_state[0], obs_match[0]);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs_match[0] !== 0) begin
      n_fail++;
      $display("FAIL post_reset_110 match=%0h required=0", obs_match[0]);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs_match[0] !== 1 || obs_cnt[0] !== 1) begin
      n_fail++;
      $display("FAIL post_reset_1101 match=%0h cnt=%0h required match=1 cnt=1",
               obs_match[0], obs_cnt[0]);
    end
  endtask

  task automatic test_single_bit();
    bit b;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      b = 1'($urandom_range(0, 1));
      drive(1'b1, b, 1'($urandom_range(0, 1)), 1'b0);
      n_checks++;
      if (obs_match[4] !== 32'(b == 1'b0) || obs_state[4] !== 32'(b == 1'b0)) begin
        n_fail++;
        $display("FAIL len1 step%0d w=%0d match=%0h state=%0h required=%0d",
                 i, b, obs_match[4], obs_state[4], b == 1'b0);
      end
    end
  endtask

  task automatic test_random();
    bit ovl;
    ovl = 1'b1;
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(0, 7) == 0) ovl = ~ovl;
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ovl,
            1'($urandom_range(0, 79) == 0));
      if ($urandom_range(0, 149) == 0) pulse_reset();
      for (int d = 0; d < NDUT; d++) begin
        n_checks++;
        if (obs_state[d] !== m_state[d] || obs_match[d] !== 32'(m_state[d] == p_len[d]) ||
            obs_cnt[d] !== m_cnt[d] || obs_sat[d] !== m_sat[d]) begin
          n_fail++;
          $display("FAIL random t%0d dut%0d state=%0h match=%0h cnt=%0h sat=%0h required state=%0d cnt=%0d sat=%0d",
                   t, d, obs_state[d], obs_match[d], obs_cnt[d], obs_sat[d],
                   m_state[d], m_cnt[d], m_sat[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap_1101(1'b1);
    test_overlap_1101(1'b0);
    test_all_ones();
    test_enable_gaps();
    test_saturation();
    test_mid_reset();
    test_single_bit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
